// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and its users.
// Purpose : default parameter values, the single-action encoding used by
//           the controller and the bench, and the priority decode helper.
// Contents: PC_*_DEFAULT localparams, pc_action_e, pc_decode_action().
package pc_sequencer_pkg;

    localparam int          PC_WS_DEFAULT        = 8;
    localparam int          PC_DEPTH_DEFAULT     = 4;
    localparam int          PC_STEP_DEFAULT      = 1;
    localparam logic [7:0]  PC_RESET_VEC_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_INC  = 3'd1,
        ACT_LOAD = 3'd2,
        ACT_CALL = 3'd3,
        ACT_RET  = 3'd4
    } pc_action_e;

    // Collapse the request lines to exactly one action: call > ret > load > inc.
    function automatic pc_action_e pc_decode_action(
        input logic call,
        input logic ret,
        input logic load_pc,
        input logic inc_pc
    );
        pc_action_e act;
        if (call) begin
            act = ACT_CALL;
        end else if (ret) begin
            act = ACT_RET;
        end else if (load_pc) begin
            act = ACT_LOAD;
        end else if (inc_pc) begin
            act = ACT_INC;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for the program-counter sequencer.
// Purpose : holds up to DEPTH return addresses; push-when-full and
//           pop-when-empty are silently rejected here (the caller flags them).
// Ports   : clk, rst (async, active-low), push, pop, din[WS], top[WS]
//           (0 while empty), sp[$clog2(DEPTH+1)], full, empty.
module ret_stack
    import pc_sequencer_pkg::*;
#(
    parameter int WS    = PC_WS_DEFAULT,
    parameter int DEPTH = PC_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WS-1:0]              din,
    output logic [WS-1:0]              top,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WS-1:0]  mem_r [DEPTH];
    logic [SPW-1:0] sp_r;
    logic           full_s;
    logic           empty_s;
    logic           push_ok_s;
    logic           pop_ok_s;
    logic [AW-1:0]  wr_idx_s;
    logic [AW-1:0]  rd_idx_s;
    logic [WS-1:0]  top_s;

    // Occupancy decode, accepted operations and RAM addressing.
    always_comb begin
        full_s   = (sp_r == SPW'(DEPTH));
        empty_s  = (sp_r == {SPW{1'b0}});
        // rst gates the write so an edge that lands while reset is held
        // cannot leave a stray entry behind.
        push_ok_s = push && !full_s && rst;
        pop_ok_s  = pop && !push && !empty_s;
        wr_idx_s  = AW'(sp_r);
        rd_idx_s  = AW'(sp_r - SPW'(1));
    end

    // Top-of-stack read: zero while empty so the controller never sees stale RAM.
    always_comb begin
        if (empty_s) begin
            top_s = {WS{1'b0}};
        end else begin
            top_s = mem_r[rd_idx_s];
        end
    end

    // Stack pointer: the only reset state of the LIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_r <= {SPW{1'b0}};
        end else if (push_ok_s) begin
            sp_r <= sp_r + SPW'(1);
        end else if (pop_ok_s) begin
            sp_r <= sp_r - SPW'(1);
        end else begin
            sp_r <= sp_r;
        end
    end

    // Return-address storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_idx_s] <= din;
        end
    end

    assign top   = top_s;
    assign sp    = sp_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter for the RISC-SPM control path.
// Purpose : sequential increment, absolute jump and call/return through an
//           internal return-address LIFO, with sticky overflow/underflow flags.
// Ports   : clk, rst (async, active-low), data_in[WS], load_pc, inc_pc,
//           call, ret, clr_err -> count[WS], ret_addr[WS], sp, stack_full,
//           stack_empty, ovf_err, unf_err.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int            WS        = PC_WS_DEFAULT,
    parameter int            DEPTH     = PC_DEPTH_DEFAULT,
    parameter int            STEP      = PC_STEP_DEFAULT,
    parameter logic [WS-1:0] RESET_VEC = WS'(PC_RESET_VEC_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WS-1:0]              data_in,
    input  logic                       load_pc,
    input  logic                       inc_pc,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       clr_err,
    output logic [WS-1:0]              count,
    output logic [WS-1:0]              ret_addr,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    pc_action_e                 act_s;
    logic [WS-1:0]              count_r;
    logic [WS-1:0]              next_seq_s;
    logic [WS-1:0]              top_s;
    logic [$clog2(DEPTH+1)-1:0] sp_s;
    logic                       full_s;
    logic                       empty_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       ovf_set_s;
    logic                       unf_set_s;
    logic                       ovf_err_r;
    logic                       unf_err_r;

    // Single-action decode; the sum wraps modulo 2^WS and is also the pushed return address.
    always_comb begin
        act_s      = pc_decode_action(call, ret, load_pc, inc_pc);
        next_seq_s = count_r + WS'(STEP);
        push_s     = (act_s == ACT_CALL);
        pop_s      = (act_s == ACT_RET);
        ovf_set_s  = push_s && full_s;
        unf_set_s  = pop_s && empty_s;
    end

    ret_stack #(
        .WS    (WS),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (next_seq_s),
        .top   (top_s),
        .sp    (sp_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Program counter register; a rejected call/ret holds count for the cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= RESET_VEC;
        end else begin
            case (act_s)
                ACT_CALL: count_r <= full_s  ? count_r : data_in;
                ACT_RET:  count_r <= empty_s ? count_r : top_s;
                ACT_LOAD: count_r <= data_in;
                ACT_INC:  count_r <= next_seq_s;
                default:  count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags: a new error outranks clr_err in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err_r <= 1'b0;
            unf_err_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_err_r <= 1'b1;
            end else if (clr_err) begin
                ovf_err_r <= 1'b0;
            end else begin
                ovf_err_r <= ovf_err_r;
            end
            if (unf_set_s) begin
                unf_err_r <= 1'b1;
            end else if (clr_err) begin
                unf_err_r <= 1'b0;
            end else begin
                unf_err_r <= unf_err_r;
            end
        end
    end

    assign count       = count_r;
    assign ret_addr    = top_s;
    assign sp          = sp_s;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign ovf_err     = ovf_err_r;
    assign unf_err     = unf_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (WS=8, DEPTH=4, STEP=1, RESET_VEC=8'h10).
// Each driven cycle updates a reference model and queues the expected
// outputs; after the clock edge the entry is popped and compared.
module tb_pc_sequencer;

    localparam int         WS    = 8;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RV    = 8'h10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       load_pc = 1'b0;
    logic       inc_pc  = 1'b1;
    logic       call    = 1'b0;
    logic       ret     = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] count;
    logic [7:0] ret_addr;
    logic [2:0] sp;
    logic       stack_full;
    logic       stack_empty;
    logic       ovf_err;
    logic       unf_err;

    pc_sequencer #(
        .WS        (WS),
        .DEPTH     (DEPTH),
        .STEP      (1),
        .RESET_VEC (RV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .load_pc     (load_pc),
        .inc_pc      (inc_pc),
        .call        (call),
        .ret         (ret),
        .clr_err     (clr_err),
        .count       (count),
        .ret_addr    (ret_addr),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] count;
        logic [7:0] ret_addr;
        logic [2:0] sp;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_count;
    int   m_sp;
    int   m_stack[DEPTH];
    bit   m_ovf;
    bit   m_unf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count = int'(RV);
        m_sp    = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit r, input bit l, input bit i,
                              input bit clr, input int d);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (c) begin
            if (m_sp == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                m_stack[m_sp] = (m_count + 1) % 256;
                m_sp++;
                m_count = d;
            end
        end else if (r) begin
            if (m_sp == 0) begin
                m_unf = 1'b1;
            end else begin
                m_sp--;
                m_count = m_stack[m_sp];
            end
        end else if (l) begin
            m_count = d;
        end else if (i) begin
            m_count = (m_count + 1) % 256;
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.count    = 8'(m_count);
        e.ret_addr = (m_sp > 0) ? 8'(m_stack[m_sp - 1]) : 8'h00;
        e.sp       = 3'(m_sp);
        e.full     = (m_sp == DEPTH);
        e.empty    = (m_sp == 0);
        e.ovf      = m_ovf;
        e.unf      = m_unf;
        return e;
    endfunction

    task automatic compare_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_count"},    32'(count),       32'(e.count));
            check_eq({tag, "_ret_addr"}, 32'(ret_addr),    32'(e.ret_addr));
            check_eq({tag, "_sp"},       32'(sp),          32'(e.sp));
            check_eq({tag, "_full"},     32'(stack_full),  32'(e.full));
            check_eq({tag, "_empty"},    32'(stack_empty), 32'(e.empty));
            check_eq({tag, "_ovf"},      32'(ovf_err),     32'(e.ovf));
            check_eq({tag, "_unf"},      32'(unf_err),     32'(e.unf));
        end
    endtask

    task automatic cycle(input bit c, input bit r, input bit l, input bit i,
                         input bit clr, input logic [7:0] d, input string tag);
        @(negedge clk);
        call    = c;
        ret     = r;
        load_pc = l;
        inc_pc  = i;
        clr_err = clr;
        data_in = d;
        model_step(c, r, l, i, clr, int'(d));
        exp_q.push_back(model_snapshot());
        @(posedge clk);
        #1;
        compare_pop(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset held across edges with inc_pc active.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(model_snapshot());
        compare_pop("reset");
        @(negedge clk);
        inc_pc = 1'b0;
        rst    = 1'b1;
        cycle(0, 0, 0, 1, 0, 8'h00, "inc1");
        cycle(0, 0, 0, 1, 0, 8'h00, "inc2");
        cycle(0, 0, 0, 1, 0, 8'h00, "inc3");
        // 2. Wrap on increment and on the pushed return address.
        cycle(0, 0, 1, 0, 0, 8'hFF, "load_ff");
        cycle(0, 0, 0, 1, 0, 8'h00, "wrap_inc");
        cycle(0, 0, 1, 0, 0, 8'hFF, "load_ff2");
        cycle(1, 0, 0, 0, 0, 8'h40, "call_wrap");
        cycle(0, 1, 0, 0, 0, 8'h00, "ret_wrap");
        // 3. Nesting.
        cycle(0, 0, 1, 0, 0, 8'h20, "load_20");
        cycle(1, 0, 0, 0, 0, 8'h30, "call_30");
        cycle(1, 0, 0, 0, 0, 8'h50, "call_50");
        cycle(1, 0, 0, 0, 0, 8'h70, "call_70");
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0, 8'h00, "ret_nest");
        // 4. Overflow then clear.
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0, 0, 8'(8'h80 + k), "call_ovf");
        cycle(0, 0, 0, 0, 1, 8'h00, "clr_ovf");
        for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 0, 8'h00, "drain");
        // 5. Underflow and priority.
        cycle(0, 1, 0, 1, 0, 8'h00, "ret_unf");
        cycle(1, 1, 1, 1, 0, 8'hA0, "prio_call");
        cycle(0, 1, 0, 0, 0, 8'h00, "ret_prio");
        cycle(0, 1, 0, 0, 1, 8'h00, "clr_vs_unf");
        cycle(0, 0, 0, 0, 1, 8'h00, "clr_unf");
        // Mixed random traffic.
        for (int k = 0; k < 60; k++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                  $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)), "rand");
        end
        // 6. Asynchronous reset with sp=2 and a call pending.
        cycle(0, 0, 0, 0, 1, 8'h00, "pre_clr");
        while (m_sp > 0) cycle(0, 1, 0, 0, 0, 8'h00, "pre_drain");
        cycle(1, 0, 0, 0, 0, 8'h60, "pre_call1");
        cycle(1, 0, 0, 0, 0, 8'h68, "pre_call2");
        @(negedge clk);
        call    = 1'b1;
        data_in = 8'h55;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_snapshot());
        compare_pop("async_rst");
        @(posedge clk);
        #1;
        exp_q.push_back(model_snapshot());
        compare_pop("rst_edge");
        @(negedge clk);
        call = 1'b0;
        rst  = 1'b1;
        cycle(0, 0, 0, 0, 0, 8'h00, "post_rst");
        cycle(0, 1, 0, 0, 0, 8'h00, "post_rst_ret");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
